// File: rtl/servile_wb_rr_arbiter_if.sv
// Single Wishbone link (request + response) shared by the arbiter's master and slave sides.
// rd_slave is the reduced view used for the read-only instruction bus.
interface servile_wb_rr_arbiter_if;
   logic [31:0] adr;
   logic [31:0] dat;
   logic [3:0]  sel;
   logic        we;
   logic        stb;
   logic [31:0] rdt;
   logic        ack;

   modport master   (output adr, dat, sel, we, stb, input rdt, ack);
   modport slave    (input adr, dat, sel, we, stb, output rdt, ack);
   modport rd_slave (input adr, stb, output rdt, ack);
endinterface

// File: rtl/servile_wb_rr_arbiter.sv
// Three-master Wishbone round-robin arbiter (ibus, dbus, aux) onto one memory port.
// Registered grant gives one IDLE arbitration cycle per access; optional ack timeout.
module servile_wb_rr_arbiter #(
   parameter int unsigned TIMEOUT  = 256,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF,
   parameter int unsigned TW       = $clog2(TIMEOUT + 1)
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   servile_wb_rr_arbiter_if.rd_slave       wb_m0,
   servile_wb_rr_arbiter_if.slave          wb_m1,
   servile_wb_rr_arbiter_if.slave          wb_m2,
   servile_wb_rr_arbiter_if.master         wb_mem,
   output logic [2:0]                      o_grant,
   output logic                            o_timeout
);

   localparam int unsigned CW = (TW > 0) ? TW : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state, state_nxt;
   logic [2:0]    grant, grant_nxt;
   logic [1:0]    last, last_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    stb;
   logic          gstb;
   logic          tmo;
   logic          done;
   logic          found;
   logic [1:0]    cand;

   assign stb = {wb_m2.stb, wb_m1.stb, wb_m0.stb};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         grant <= '0;
         last  <= 2'd2;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      gstb = |(grant & stb);
      tmo  = 1'b0;
      if (TIMEOUT != 0 && state == BUSY && gstb && !wb_mem.ack &&
          cnt == CW'(TIMEOUT - 1))
         tmo = 1'b1;
      done = (state == BUSY) && gstb && (wb_mem.ack || tmo);
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      last_nxt  = last;
      cnt_nxt   = cnt;
      found     = 1'b0;
      cand      = '0;
      case (state)
         IDLE: begin
            // Search order last+1, last+2, last+3 (mod 3); first hit wins.
            for (int unsigned k = 1; k <= 3; k++) begin
               cand = 2'((32'(last) + k) % 3);
               if (!found && stb[cand]) begin
                  found     = 1'b1;
                  grant_nxt = 3'b001 << cand;
               end
            end
            if (found) begin
               state_nxt = BUSY;
               cnt_nxt   = '0;
            end
         end
         BUSY: begin
            if (!gstb) begin
               state_nxt = IDLE;
               grant_nxt = '0;
            end else if (done) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               last_nxt  = grant[2] ? 2'd2 : (grant[1] ? 2'd1 : 2'd0);
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wb_mem.adr = '0;
      wb_mem.dat = '0;
      wb_mem.sel = '0;
      wb_mem.we  = 1'b0;
      if (state == BUSY) begin
         case (grant)
            3'b001: begin
               wb_mem.adr = wb_m0.adr;
               wb_mem.sel = 4'hF;
            end
            3'b010: begin
               wb_mem.adr = wb_m1.adr;
               wb_mem.dat = wb_m1.dat;
               wb_mem.sel = wb_m1.sel;
               wb_mem.we  = wb_m1.we;
            end
            3'b100: begin
               wb_mem.adr = wb_m2.adr;
               wb_mem.dat = wb_m2.dat;
               wb_mem.sel = wb_m2.sel;
               wb_mem.we  = wb_m2.we;
            end
            default: ;
         endcase
      end
      // A timeout completes toward the master and withdraws the slave request together.
      wb_mem.stb = (state == BUSY) && gstb && !tmo;
      wb_m0.rdt  = tmo ? ERR_DATA : wb_mem.rdt;
      wb_m1.rdt  = tmo ? ERR_DATA : wb_mem.rdt;
      wb_m2.rdt  = tmo ? ERR_DATA : wb_mem.rdt;
      wb_m0.ack  = done && grant[0];
      wb_m1.ack  = done && grant[1];
      wb_m2.ack  = done && grant[2];
      o_grant    = grant;
      o_timeout  = tmo;
   end

endmodule

// File: tb/tb_servile_wb_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_servile_wb_rr_arbiter;

   localparam int unsigned TMO = 4;
   localparam logic [31:0] ERR = 32'hDEADBEEF;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] grant;
   logic       tmo_o;

   servile_wb_rr_arbiter_if m0_if ();
   servile_wb_rr_arbiter_if m1_if ();
   servile_wb_rr_arbiter_if m2_if ();
   servile_wb_rr_arbiter_if mem_if ();

   servile_wb_rr_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .wb_m0    (m0_if),
      .wb_m1    (m1_if),
      .wb_m2    (m2_if),
      .wb_mem   (mem_if),
      .o_grant  (grant),
      .o_timeout(tmo_o)
   );

   always #5 clk = ~clk;

   // master agents
   bit          req   [3];
   logic [31:0] a_adr [3];
   logic [31:0] a_dat [3];
   logic [3:0]  a_sel [3];
   logic        a_we  [3];

   // reference model: who owns the bus (-1 = nobody), how long they have waited, last served
   int owner;
   int waited;
   int last;

   int  ack_mode;   // 0 random, 1 never, 2 always, 3 only on final timeout cycle
   bit  rand_mode;
   bit  hold;
   int  n_vec = 0;
   int  n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic new_req(input int i);
      req[i]   = 1'b1;
      a_adr[i] = $urandom;
      a_dat[i] = $urandom;
      a_sel[i] = 4'($urandom);
      a_we[i]  = 1'($urandom);
   endtask

   task automatic drive();
      m0_if.adr = a_adr[0];
      m0_if.dat = $urandom;
      m0_if.sel = 4'($urandom);
      m0_if.we  = 1'($urandom);
      m0_if.stb = req[0];
      m1_if.adr = a_adr[1];
      m1_if.dat = a_dat[1];
      m1_if.sel = a_sel[1];
      m1_if.we  = a_we[1];
      m1_if.stb = req[1];
      m2_if.adr = a_adr[2];
      m2_if.dat = a_dat[2];
      m2_if.sel = a_sel[2];
      m2_if.we  = a_we[2];
      m2_if.stb = req[2];
   endtask

   task automatic step(input bit do_rst, input bit chk);
      logic        s_ack;
      logic [31:0] s_rdt;
      logic [2:0]  e_grant, e_ack, g_ack;
      logic        e_stb, e_tmo;
      logic [31:0] e_rdt, g_rdt [3];
      logic [31:0] e_dat;
      logic [3:0]  e_sel;
      logic        e_we;
      bit          found;
      int          c;

      rst = do_rst;
      drive();
      case (ack_mode)
         0:       s_ack = ($urandom % 4) == 0;
         1:       s_ack = 1'b0;
         2:       s_ack = 1'b1;
         default: s_ack = (owner >= 0) && (waited == TMO - 1);
      endcase
      s_rdt      = $urandom;
      mem_if.ack = s_ack;
      mem_if.rdt = s_rdt;

      @(negedge clk);
      e_grant = '0;
      e_stb   = 1'b0;
      e_tmo   = 1'b0;
      e_ack   = '0;
      e_rdt   = s_rdt;
      if (owner >= 0) begin
         e_grant = 3'b001 << owner;
         e_tmo   = req[owner] && !s_ack && (waited == TMO - 1);
         e_stb   = req[owner] && !e_tmo;
         if (req[owner] && (s_ack || e_tmo)) e_ack = 3'b001 << owner;
         if (e_tmo) e_rdt = ERR;
      end

      if (chk) begin
         g_ack = {m2_if.ack, m1_if.ack, m0_if.ack};
         g_rdt = '{m0_if.rdt, m1_if.rdt, m2_if.rdt};
         check("grant",   32'(grant),      32'(e_grant));
         check("mem_stb", 32'(mem_if.stb), 32'(e_stb));
         check("timeout", 32'(tmo_o),      32'(e_tmo));
         check("acks",    32'(g_ack),      32'(e_ack));
         if (e_stb) begin
            e_dat = (owner == 0) ? 32'h0  : a_dat[owner];
            e_sel = (owner == 0) ? 4'hF   : a_sel[owner];
            e_we  = (owner == 0) ? 1'b0   : a_we[owner];
            check("mem_adr", mem_if.adr,      a_adr[owner]);
            check("mem_dat", mem_if.dat,      e_dat);
            check("mem_sel", 32'(mem_if.sel), 32'(e_sel));
            check("mem_we",  32'(mem_if.we),  32'(e_we));
         end
         if (e_ack != 0) check("rdt", g_rdt[owner], e_rdt);
      end

      // advance the model
      if (owner < 0) begin
         found = 1'b0;
         for (int k = 1; k <= 3; k++) begin
            c = (last + k) % 3;
            if (!found && req[c]) begin
               found  = 1'b1;
               owner  = c;
               waited = 0;
            end
         end
      end else if (!req[owner]) begin
         owner = -1;
      end else if (e_ack != 0) begin
         last  = owner;
         owner = -1;
      end else begin
         waited++;
      end
      if (do_rst) begin
         owner  = -1;
         last   = 2;
         waited = 0;
      end

      // agents react to their acks
      for (int i = 0; i < 3; i++) begin
         if (e_ack[i]) begin
            if (rand_mode ? (($urandom % 2) == 1) : hold) new_req(i);
            else req[i] = 1'b0;
         end else if (rand_mode) begin
            if (!req[i] && ($urandom % 4) == 0) new_req(i);
            else if (req[i] && ($urandom % 64) == 0) req[i] = 1'b0;
         end
      end

      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         req[i] = 1'b0; a_adr[i] = '0; a_dat[i] = '0; a_sel[i] = '0; a_we[i] = 1'b0;
      end
      owner = -1; last = 2; waited = 0;
      ack_mode = 1; rand_mode = 1'b0; hold = 1'b0;
      #1;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);

      // single ibus read
      ack_mode = 2;
      new_req(0);
      a_adr[0] = 32'h100;
      repeat (4) step(1'b0, 1'b1);

      // all three masters hold stb continuously
      hold = 1'b1;
      new_req(0); new_req(1); new_req(2);
      repeat (12) step(1'b0, 1'b1);
      hold = 1'b0;
      repeat (6) step(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) req[i] = 1'b0;
      step(1'b0, 1'b1);

      // dbus write
      new_req(1);
      a_adr[1] = 32'h2000; a_dat[1] = 32'h12345678; a_sel[1] = 4'b0011; a_we[1] = 1'b1;
      repeat (4) step(1'b0, 1'b1);

      // aux read with no slave ack: forced error completion
      ack_mode = 1;
      new_req(2);
      a_we[2] = 1'b0;
      repeat (7) step(1'b0, 1'b1);

      // slave ack lands exactly in the timeout cycle
      ack_mode = 3;
      new_req(2);
      repeat (7) step(1'b0, 1'b1);

      // reset while dbus is granted, then m1 and m2 contend
      ack_mode = 1;
      new_req(1); new_req(2);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      repeat (6) step(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) req[i] = 1'b0;
      repeat (2) step(1'b0, 1'b1);

      // random traffic
      rand_mode = 1'b1;
      ack_mode  = 0;
      for (int n = 0; n < 3000; n++) step(($urandom % 200) == 0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
